// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the three bus groups around the data-memory arbiter.
//   p_* : pipeline Memory-stage requester (request, store data, load data, done, stall)
//   h_* : host loader requester (request, grant, read-valid, read data)
//   m_* : single-port data memory (strobe, write enable, address, data)
//   busy: read in flight
// Modports:
//   slave  - the arbiter's view (serves the requesters, drives the memory)
//   master - the environment's view (requesters plus memory model)

interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 32
);

  // Pipeline requester
  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;
  logic              p_done;
  logic              stall_o;

  // Host requester
  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  // Memory port
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  logic              busy;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_rdata, p_done, stall_o,
    input  h_req, h_we, h_addr, h_wdata,
    output h_gnt, h_rvalid, h_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata,
    output busy
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_rdata, p_done, stall_o,
    output h_req, h_we, h_addr, h_wdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata,
    input  busy
  );

endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data-memory arbiter and stall controller for the SIMD pipeline.
// Shares one DATA_W-wide memory between the pipeline Memory stage (P) and a host loader (H),
// serialises their accesses and sequences the fixed memory read latency.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - dmem_arbiter_if.slave: P request/done/stall, H request/grant/rvalid, memory port, busy
// Behaviour summary:
//   IDLE    : the arbitration winner issues combinationally; writes complete in the issue cycle,
//             reads move to RD_WAIT with the owner latched.
//   RD_WAIT : no issue; after RD_LAT cycles the owner receives m_rdata and the FSM returns to IDLE.
//   P wins by default; H wins when P is idle or after STARVE_LIM consecutive P wins over a
//   waiting H.

module dmem_arbiter #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RD_LAT     = 2,   // 1..7
  parameter int unsigned STARVE_LIM = 4    // 1..15
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;
  typedef enum logic [0:0] {OwnP, OwnH}       owner_e;

  localparam logic [2:0] RdLat     = 3'(RD_LAT);
  localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [2:0] lat_cnt_q, lat_cnt_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  logic p_win;
  logic h_win;
  logic rd_last;

  // Arbitration only happens in IDLE; H is forced through once P has won STARVE_LIM times in a
  // row while H was waiting.
  always_comb begin
    h_win   = (state_q == StIdle) && bus.h_req &&
              (!bus.p_req || (starve_cnt_q == StarveLim));
    p_win   = (state_q == StIdle) && bus.p_req && !h_win;
    rd_last = (state_q == StRdWait) && (lat_cnt_q == RdLat);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnP;
      lat_cnt_q    <= 3'd0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      StIdle: begin
        if (p_win && !bus.p_we) begin
          state_d   = StRdWait;
          owner_d   = OwnP;
          lat_cnt_d = 3'd1;
        end else if (h_win && !bus.h_we) begin
          state_d   = StRdWait;
          owner_d   = OwnH;
          lat_cnt_d = 3'd1;
        end
      end
      StRdWait: begin
        if (rd_last) begin
          state_d   = StIdle;
          lat_cnt_d = 3'd0;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Starvation counter: an H grant or an absent H request clears it; otherwise each P win
  // counts. It saturates naturally because H wins as soon as it reaches the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (h_win) begin
      starve_cnt_d = 4'd0;
    end else if (!bus.h_req) begin
      starve_cnt_d = 4'd0;
    end else if (p_win) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Outputs. Everything is qualified by rst so that all outputs, including the purely
  // combinational issue path and stall, read 0 while reset is asserted.
  logic              p_done;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

  always_comb begin
    p_done       = 1'b0;
    issue_addr   = {ADDR_W{1'b0}};
    issue_wdata  = {DATA_W{1'b0}};
    bus.m_en     = 1'b0;
    bus.m_we     = 1'b0;
    bus.p_rdata  = {DATA_W{1'b0}};
    bus.h_gnt    = 1'b0;
    bus.h_rvalid = 1'b0;
    bus.h_rdata  = {DATA_W{1'b0}};
    bus.busy     = 1'b0;
    bus.stall_o  = 1'b0;
    if (rst) begin
      if (p_win) begin
        bus.m_en    = 1'b1;
        bus.m_we    = bus.p_we;
        issue_addr  = bus.p_addr;
        issue_wdata = bus.p_wdata;
        p_done      = bus.p_we;  // stores finish in the issue cycle
      end else if (h_win) begin
        bus.m_en    = 1'b1;
        bus.m_we    = bus.h_we;
        issue_addr  = bus.h_addr;
        issue_wdata = bus.h_wdata;
        bus.h_gnt   = 1'b1;
      end
      if (rd_last) begin
        if (owner_q == OwnP) begin
          p_done      = 1'b1;
          bus.p_rdata = bus.m_rdata;
        end else begin
          bus.h_rvalid = 1'b1;
          bus.h_rdata  = bus.m_rdata;
        end
      end
      bus.busy    = (state_q == StRdWait);
      // Pipeline advances on the edge that ends the p_done cycle.
      bus.stall_o = bus.p_req && !p_done;
    end
    bus.m_addr  = issue_addr;
    bus.m_wdata = issue_wdata;
    bus.p_done  = p_done;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter (RD_LAT=2, STARVE_LIM=4).
// Cycle-by-cycle vectors carry inputs plus expected control outputs; read data is tracked by a
// scoreboard filled when a read issue is expected and drained when the DUT signals completion.
// A small memory model returns mem_fn(addr) exactly RD_LAT cycles after each read issue.

module tb_dmem_arbiter;

  localparam int unsigned DataW     = 256;
  localparam int unsigned AddrW     = 32;
  localparam int unsigned RdLat     = 2;
  localparam int unsigned StarveLim = 4;

  typedef struct {
    logic        p_req, p_we;
    logic [31:0] p_addr;
    logic        h_req, h_we;
    logic [31:0] h_addr;
    logic        e_en, e_we;
    logic [31:0] e_addr;
    logic        e_h;       // expected winner is H (selects expected wdata)
    logic        e_pdone, e_stall, e_hgnt, e_hrv, e_busy;
  } vec_t;

  typedef struct {
    bit           is_h;
    logic [255:0] data;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  sb_item_t sb_q[$];
  vec_t     tbl[16];

  dmem_arbiter_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus ();

  dmem_arbiter #(
    .DATA_W    (DataW),
    .ADDR_W    (AddrW),
    .RD_LAT    (RdLat),
    .STARVE_LIM(StarveLim)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mem_fn(input logic [31:0] a);
    return {32{a[7:0] ^ 8'hA5}};
  endfunction

  function automatic logic [255:0] ppat(input logic [31:0] a);
    return {8{a ^ 32'h1111_0000}};
  endfunction

  function automatic logic [255:0] hpat(input logic [31:0] a);
    return {8{~a}};
  endfunction

  // Memory model: fixed-latency read pipe.
  logic        pipe_v [RdLat];
  logic [31:0] pipe_a [RdLat];

  initial begin
    for (int i = 0; i < int'(RdLat); i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = 32'd0;
    end
  end

  always @(posedge clk) begin
    pipe_v[0] <= bus.m_en && !bus.m_we;
    pipe_a[0] <= bus.m_addr;
    for (int i = 1; i < int'(RdLat); i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end

  assign bus.m_rdata = pipe_v[RdLat-1] ? mem_fn(pipe_a[RdLat-1]) : {8{32'hDEADBEEF}};

  function automatic vec_t mk(input logic pr, input logic pw, input logic [31:0] pa,
                              input logic hr, input logic hw, input logic [31:0] ha,
                              input logic en, input logic we, input logic [31:0] ad,
                              input logic eh, input logic pd, input logic st,
                              input logic hg, input logic hv, input logic bz);
    vec_t v;
    v.p_req = pr; v.p_we = pw; v.p_addr = pa;
    v.h_req = hr; v.h_we = hw; v.h_addr = ha;
    v.e_en = en; v.e_we = we; v.e_addr = ad; v.e_h = eh;
    v.e_pdone = pd; v.e_stall = st; v.e_hgnt = hg; v.e_hrv = hv; v.e_busy = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive, settle, compare, advance to the next falling edge.
  task automatic apply(input string tag, input vec_t v);
    sb_item_t     it;
    logic [255:0] exp_p;
    logic [255:0] exp_h;
    bus.p_req   = v.p_req;
    bus.p_we    = v.p_we;
    bus.p_addr  = v.p_addr;
    bus.p_wdata = ppat(v.p_addr);
    bus.h_req   = v.h_req;
    bus.h_we    = v.h_we;
    bus.h_addr  = v.h_addr;
    bus.h_wdata = hpat(v.h_addr);
    if (v.e_en && !v.e_we) begin
      it.is_h = v.e_h;
      it.data = mem_fn(v.e_addr);
      sb_q.push_back(it);
    end
    #1;
    chk({tag, " flags"},
        256'({bus.m_en, bus.m_we, bus.p_done, bus.stall_o, bus.h_gnt, bus.h_rvalid, bus.busy}),
        256'({v.e_en, v.e_we, v.e_pdone, v.e_stall, v.e_hgnt, v.e_hrv, v.e_busy}));
    chk({tag, " m_addr"}, 256'(bus.m_addr), v.e_en ? 256'(v.e_addr) : 256'd0);
    chk({tag, " m_wdata"}, bus.m_wdata,
        !v.e_en ? 256'd0 : (v.e_h ? hpat(v.e_addr) : ppat(v.e_addr)));
    exp_p = '0;
    exp_h = '0;
    // A P completion without an issue in the same cycle is a read completion.
    if (bus.h_rvalid || (bus.p_done && !bus.m_en)) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL %s rd_pop: got read completion, want none outstanding", tag);
      end else begin
        it = sb_q.pop_front();
        if (it.is_h) exp_h = it.data;
        else         exp_p = it.data;
      end
    end
    chk({tag, " p_rdata"}, bus.p_rdata, exp_p);
    chk({tag, " h_rdata"}, bus.h_rdata, exp_h);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " flags"},
        256'({bus.m_en, bus.m_we, bus.p_done, bus.stall_o, bus.h_gnt, bus.h_rvalid, bus.busy}),
        256'd0);
    chk({tag, " m_addr"}, 256'(bus.m_addr), 256'd0);
    chk({tag, " m_wdata"}, bus.m_wdata, 256'd0);
    chk({tag, " rdata"}, bus.p_rdata | bus.h_rdata, 256'd0);
  endtask

  vec_t z;

  initial begin
    z = mk(0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0,0);
    //           P req          H req           expected issue       pd st hg hv bz
    tbl[0]  = z;
    tbl[1]  = mk(1,1,32'h10, 0,0,0,       1,1,32'h10, 0, 1,0,0,0,0);  // P store
    tbl[2]  = mk(1,0,32'h00, 0,0,0,       1,0,32'h00, 0, 0,1,0,0,0);  // P load issue
    tbl[3]  = mk(1,0,32'h00, 0,0,0,       0,0,0,      0, 0,1,0,0,1);
    tbl[4]  = mk(1,0,32'h00, 0,0,0,       0,0,0,      0, 1,0,0,0,1);  // A5..A5 returns
    tbl[5]  = mk(1,0,32'h04, 1,1,32'h30,  1,0,32'h04, 0, 0,1,0,0,0);  // P load beats H write
    tbl[6]  = mk(1,0,32'h04, 1,1,32'h30,  0,0,0,      0, 0,1,0,0,1);
    tbl[7]  = mk(1,0,32'h04, 1,1,32'h30,  0,0,0,      0, 1,0,0,0,1);
    tbl[8]  = mk(0,0,0,      1,1,32'h30,  1,1,32'h30, 1, 0,0,1,0,0);  // H write after p_done
    tbl[9]  = mk(0,0,0,      1,0,32'h20,  1,0,32'h20, 1, 0,0,1,0,0);  // H load 0x20
    tbl[10] = mk(1,0,32'h08, 0,0,0,       0,0,0,      0, 0,1,0,0,1);  // P load arrives
    tbl[11] = mk(1,0,32'h08, 0,0,0,       0,0,0,      0, 0,1,0,1,1);  // h_rvalid
    tbl[12] = mk(1,0,32'h08, 0,0,0,       1,0,32'h08, 0, 0,1,0,0,0);
    tbl[13] = mk(1,0,32'h08, 0,0,0,       0,0,0,      0, 0,1,0,0,1);
    tbl[14] = mk(1,0,32'h08, 0,0,0,       0,0,0,      0, 1,0,0,0,1);  // 5th cycle of p_req
    tbl[15] = z;

    // Reset with both requests asserted: every output must read 0.
    rst = 1'b0;
    bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h10; bus.p_wdata = ppat(32'h10);
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 32'h20; bus.h_wdata = hpat(32'h20);
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // Starvation: H held with P storing every cycle; H forced through on the 5th cycle.
    apply("starve0", mk(1,1,32'h100, 1,1,32'h40, 1,1,32'h100, 0, 1,0,0,0,0));
    apply("starve1", mk(1,1,32'h101, 1,1,32'h40, 1,1,32'h101, 0, 1,0,0,0,0));
    apply("starve2", mk(1,1,32'h102, 1,1,32'h40, 1,1,32'h102, 0, 1,0,0,0,0));
    apply("starve3", mk(1,1,32'h103, 1,1,32'h40, 1,1,32'h103, 0, 1,0,0,0,0));
    apply("starve4", mk(1,1,32'h104, 1,1,32'h40, 1,1,32'h40,  1, 0,1,1,0,0));
    apply("starve5", mk(1,1,32'h104, 0,0,0,      1,1,32'h104, 0, 1,0,0,0,0));
    apply("starve6", mk(1,1,32'h105, 1,1,32'h44, 1,1,32'h105, 0, 1,0,0,0,0));
    apply("starve7", mk(0,0,0,       1,1,32'h44, 1,1,32'h44,  1, 0,0,1,0,0));
    apply("starve8", z);

    // Reset in the completion cycle of a P load: read is dropped, outputs clear at once.
    apply("rstrd0", mk(1,0,32'h50, 0,0,0, 1,0,32'h50, 0, 0,1,0,0,0));
    apply("rstrd1", mk(1,0,32'h50, 0,0,0, 0,0,0,      0, 0,1,0,0,1));
    rst = 1'b0;
    void'(sb_q.pop_back());  // the 0x50 read never completes
    #1;
    chk_all_zero("rst_in_rdwait");
    bus.p_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    apply("post_rst0", z);
    apply("post_rst1", z);
    apply("post_rst2", z);
    apply("post_ld0", mk(1,0,32'h60, 0,0,0, 1,0,32'h60, 0, 0,1,0,0,0));
    apply("post_ld1", mk(1,0,32'h60, 0,0,0, 0,0,0,      0, 0,1,0,0,1));
    apply("post_ld2", mk(1,0,32'h60, 0,0,0, 0,0,0,      0, 1,0,0,0,1));
    apply("post_hld0", mk(0,0,0, 1,0,32'h70, 1,0,32'h70, 1, 0,0,1,0,0));
    apply("post_hld1", mk(0,0,0, 0,0,0,      0,0,0,      0, 0,0,0,0,1));
    apply("post_hld2", mk(0,0,0, 0,0,0,      0,0,0,      0, 0,0,0,1,1));
    apply("end_idle", z);

    chk("sb_drain", 256'(sb_q.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
